vscale_htif_host: RTL and testbench

Synthesizable host-side HTIF agent that sits directly downstream of vscale_sim_top's HTIF PCR port and replaces ad-hoc polling of the tohost CSR. It repeatedly reads tohost over the PCR request/response handshake and decodes each nonzero value as either a console character or an exit command. After a console character is consumed it clears tohost. It also enforces a cycle budget and reports pass, fail or timeout.

---
 rtl/vscale_htif_host_if.sv | 29 ++
 rtl/vscale_htif_host.sv | 145 ++++++++++++++
 tb/tb_vscale_htif_host.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_htif_host_if.sv
// Host-side HTIF bus: PCR request/response handshake plus the console byte stream.
// The host agent uses the master modport; the PCR port / console sink use the slave modport.
interface vscale_htif_host_if #(
   parameter int W = 64
);
   logic          htif_pcr_req_valid;
   logic          htif_pcr_req_ready;
   logic          htif_pcr_req_rw;
   logic [11:0]   htif_pcr_req_addr;
   logic [W-1:0]  htif_pcr_req_data;
   logic          htif_pcr_resp_valid;
   logic          htif_pcr_resp_ready;
   logic [W-1:0]  htif_pcr_resp_data;
   logic          char_valid;
   logic          char_ready;
   logic [7:0]    char_data;

   modport master (
      output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
      output htif_pcr_resp_ready, char_valid, char_data,
      input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data, char_ready
   );

   modport slave (
      input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
      input  htif_pcr_resp_ready, char_valid, char_data,
      output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data, char_ready
   );
endinterface

// File: rtl/vscale_htif_host.sv
// Polls tohost over the HTIF PCR port, forwards console bytes, clears tohost after each
// byte, and reports pass / fail / timeout against a cycle budget.
//
// state    | meaning
// GAP      | idle between polls, gap down-counter running
// RD_REQ   | read request for tohost outstanding
// RD_RESP  | waiting for read data, decode on arrival
// CHAR     | console byte presented to the sink
// CLR_REQ  | write-zero request to tohost outstanding
// CLR_RESP | waiting for write acknowledge
// HALT     | finished (exit or timeout), terminal until reset
module vscale_htif_host #(
   parameter int          HTIF_PCR_WIDTH = 64,
   parameter logic [11:0] TOHOST_ADDR    = 12'h780,
   parameter int          POLL_GAP       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               max_cycles_i,
   vscale_htif_host_if.master        bus,
   output logic                      done_o,
   output logic                      pass_o,
   output logic                      timeout_o,
   output logic [HTIF_PCR_WIDTH-2:0] exit_code_o,
   output logic [63:0]               cycle_count_o
);
   localparam int W  = HTIF_PCR_WIDTH;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   // GAP lasts load+1 cycles, so loading POLL_GAP-1 yields POLL_GAP idle cycles
   localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;
   localparam logic [W-2:0]  EXIT_ONE = {{(W-2){1'b0}}, 1'b1};

   localparam logic [2:0] GAP      = 3'd0;
   localparam logic [2:0] RD_REQ   = 3'd1;
   localparam logic [2:0] RD_RESP  = 3'd2;
   localparam logic [2:0] CHAR     = 3'd3;
   localparam logic [2:0] CLR_REQ  = 3'd4;
   localparam logic [2:0] CLR_RESP = 3'd5;
   localparam logic [2:0] HALT     = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    char_q, char_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          timeout_q, timeout_d;
   logic [W-2:0]  exit_q, exit_d;
   logic [63:0]   cnt_q, cnt_d;
   logic [W-2:0]  shift;

   assign shift = bus.htif_pcr_resp_data[W-1:1];

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      char_d    = char_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      exit_d    = exit_q;
      case (state_q)
         GAP: begin
            if (gap_q == '0) state_d = RD_REQ;
            else             gap_d   = gap_q - 1'b1;
         end
         RD_REQ:
            if (bus.htif_pcr_req_ready) state_d = RD_RESP;
         RD_RESP:
            if (bus.htif_pcr_resp_valid) begin
               if (bus.htif_pcr_resp_data == '0) begin
                  state_d = GAP;
                  gap_d   = GAP_LOAD;
               end else if (bus.htif_pcr_resp_data[0]) begin
                  exit_d  = shift;
                  done_d  = 1'b1;
                  pass_d  = (shift == '0);
                  state_d = HALT;
               end else if (bus.htif_pcr_resp_data[W-1:W-8] == 8'h01) begin
                  char_d  = bus.htif_pcr_resp_data[7:0];
                  state_d = CHAR;
               end else begin
                  exit_d  = (shift == '0) ? EXIT_ONE : shift;
                  done_d  = 1'b1;
                  pass_d  = 1'b0;
                  state_d = HALT;
               end
            end
         CHAR:
            if (bus.char_ready) state_d = CLR_REQ;
         CLR_REQ:
            if (bus.htif_pcr_req_ready) state_d = CLR_RESP;
         CLR_RESP:
            if (bus.htif_pcr_resp_valid) begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
            end
         default: state_d = HALT;
      endcase
      // testing done_d lets an exit decoded this cycle win over the budget
      if (!done_d && (max_cycles_i != '0) && (cnt_q >= max_cycles_i)) begin
         done_d    = 1'b1;
         timeout_d = 1'b1;
         pass_d    = 1'b0;
         state_d   = HALT;
      end
      cnt_d = cnt_q;
      if (!done_d && (cnt_q != '1)) cnt_d = cnt_q + 64'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= GAP;
         gap_q     <= '0;
         char_q    <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         exit_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         char_q    <= char_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         exit_q    <= exit_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.htif_pcr_req_valid  = (state_q == RD_REQ) || (state_q == CLR_REQ);
   assign bus.htif_pcr_req_rw     = (state_q == CLR_REQ);
   assign bus.htif_pcr_req_addr   = bus.htif_pcr_req_valid ? TOHOST_ADDR : 12'h000;
   assign bus.htif_pcr_req_data   = '0;
   assign bus.htif_pcr_resp_ready = (state_q == RD_RESP) || (state_q == CLR_RESP);
   assign bus.char_valid          = (state_q == CHAR);
   assign bus.char_data           = char_q;

   assign done_o        = done_q;
   assign pass_o        = pass_q;
   assign timeout_o     = timeout_q;
   assign exit_code_o   = exit_q;
   assign cycle_count_o = cnt_q;
endmodule

// File: tb/tb_vscale_htif_host.sv
// Bench for vscale_htif_host: a scripted PCR responder and console sink driven once per
// cycle, with expected console bytes queued as responses are issued.
module tb_vscale_htif_host;
   localparam int POLL_GAP = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] max_cycles = '0;
   logic        done, pass, timeout;
   logic [62:0] exit_code;
   logic [63:0] cycle_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] rsp_q[$];
   logic [7:0]  char_exp[$];
   int          rd_cyc[$];
   logic        req_log[$];
   bit          rdy_en, crdy_en, stray_en, resp_pend, pend_rw, want_write, char_due, arm_boundary;
   logic [63:0] boundary_val;
   int          cyc;

   vscale_htif_host_if #(.W(64)) bus ();

   vscale_htif_host #(
      .HTIF_PCR_WIDTH (64),
      .TOHOST_ADDR    (12'h780),
      .POLL_GAP       (POLL_GAP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .max_cycles_i  (max_cycles),
      .bus           (bus),
      .done_o        (done),
      .pass_o        (pass),
      .timeout_o     (timeout),
      .exit_code_o   (exit_code),
      .cycle_count_o (cycle_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      rsp_q.delete();
      char_exp.delete();
      rd_cyc.delete();
      req_log.delete();
      rdy_en       = 1'b1;
      crdy_en      = 1'b1;
      stray_en     = 1'b0;
      resp_pend    = 1'b0;
      pend_rw      = 1'b0;
      want_write   = 1'b0;
      char_due     = 1'b0;
      arm_boundary = 1'b0;
      boundary_val = '0;
      max_cycles   = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.htif_pcr_req_ready  = 1'b0;
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data  = '0;
      bus.char_ready          = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
   endtask

   // one clock of the PCR responder and console sink, acting at the falling edge
   task automatic tick();
      logic [63:0] d;
      @(negedge clk);
      cyc++;
      if (char_due) begin
         checks++;
         if (bus.char_valid !== 1'b1) begin
            errors++;
            $display("FAIL char_latency: char_valid=%b one cycle after response, required 1", bus.char_valid);
         end
         char_due = 1'b0;
      end
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data  = '0;
      if (stray_en) begin
         bus.htif_pcr_resp_valid = 1'b1;
         bus.htif_pcr_resp_data  = 64'd1;
      end else if (resp_pend && bus.htif_pcr_resp_ready) begin
         d = 64'hDEAD_BEEF_0000_0001;
         if (!pend_rw) begin
            if (rsp_q.size() != 0) d = rsp_q.pop_front();
            else                   d = 64'd0;
            if (d[63:56] == 8'h01 && !d[0]) begin
               char_exp.push_back(d[7:0]);
               char_due = 1'b1;
            end
            if (d[0] && arm_boundary) begin
               max_cycles   = cycle_count;
               boundary_val = cycle_count;
               arm_boundary = 1'b0;
            end
         end
         bus.htif_pcr_resp_valid = 1'b1;
         bus.htif_pcr_resp_data  = d;
         resp_pend = 1'b0;
      end
      bus.htif_pcr_req_ready = rdy_en;
      if (bus.htif_pcr_req_valid) begin
         checks++;
         if (bus.htif_pcr_req_addr !== 12'h780 || bus.htif_pcr_req_data !== 64'd0 ||
             bus.htif_pcr_req_rw !== want_write) begin
            errors++;
            $display("FAIL req_fields: addr=%h data=%h rw=%b, required addr=780 data=0 rw=%b",
                     bus.htif_pcr_req_addr, bus.htif_pcr_req_data, bus.htif_pcr_req_rw, want_write);
         end
         if (rdy_en) begin
            resp_pend = 1'b1;
            pend_rw   = bus.htif_pcr_req_rw;
            req_log.push_back(bus.htif_pcr_req_rw);
            if (bus.htif_pcr_req_rw) want_write = 1'b0;
            else                     rd_cyc.push_back(cyc);
         end
      end
      bus.char_ready = crdy_en;
      if (bus.char_valid) begin
         checks++;
         if (char_exp.size() == 0) begin
            errors++;
            $display("FAIL char_unexpected: char_valid=1 data=%h, required no byte pending", bus.char_data);
         end else if (bus.char_data !== char_exp[0]) begin
            errors++;
            $display("FAIL char_data: got %h, required %h", bus.char_data, char_exp[0]);
         end
         if (crdy_en) begin
            if (char_exp.size() != 0) void'(char_exp.pop_front());
            want_write = 1'b1;
         end
      end
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_wait: done=%b after %0d cycles, required 1", tag, done, n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.htif_pcr_req_ready  = 1'b1;
      bus.htif_pcr_resp_valid = 1'b1;
      bus.htif_pcr_resp_data  = 64'd1;
      bus.char_ready          = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_resp_ready, bus.char_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_strobes: req_valid/rw/resp_ready/char_valid=%b, required 0000",
                  {bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_resp_ready, bus.char_valid});
      end
      checks++;
      if ({bus.htif_pcr_req_addr, bus.htif_pcr_req_data, bus.char_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h data=%h char=%h, required 0",
                  bus.htif_pcr_req_addr, bus.htif_pcr_req_data, bus.char_data);
      end
      checks++;
      if ({done, pass, timeout} !== 3'b0 || exit_code !== '0 || cycle_count !== '0) begin
         errors++;
         $display("FAIL reset_status: done=%b pass=%b timeout=%b exit=%h count=%0d, required all 0",
                  done, pass, timeout, exit_code, cycle_count);
      end
   endtask

   task automatic test_exit_pass();
      int nreq;
      do_reset();
      rsp_q = '{64'd0, 64'd0, 64'd0, 64'd1};
      run_until_done(200, "exit_pass");
      checks++;
      if (pass !== 1'b1 || exit_code !== 63'd0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL exit_pass_status: pass=%b exit=%h timeout=%b, required 1 0 0", pass, exit_code, timeout);
      end
      checks++;
      if (rd_cyc.size() != 4) begin
         errors++;
         $display("FAIL exit_pass_reads: %0d reads, required 4", rd_cyc.size());
      end
      for (int i = 1; i < rd_cyc.size(); i++) begin
         checks++;
         if (rd_cyc[i] - rd_cyc[i-1] != POLL_GAP + 2) begin
            errors++;
            $display("FAIL poll_gap: read spacing %0d cycles, required %0d", rd_cyc[i] - rd_cyc[i-1], POLL_GAP + 2);
         end
      end
      nreq = req_log.size();
      repeat (10) tick();
      checks++;
      if (req_log.size() != nreq || bus.htif_pcr_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_quiet: %0d requests after done, req_valid=%b, required 0 and 0",
                  req_log.size() - nreq, bus.htif_pcr_req_valid);
      end
   endtask

   task automatic test_char();
      int  n = 0;
      logic exp_log [3];
      exp_log[0] = 1'b0;
      exp_log[1] = 1'b1;
      exp_log[2] = 1'b0;
      do_reset();
      crdy_en = 1'b0;
      rsp_q = '{64'h0100_0000_0000_0048, 64'd1};
      while (bus.char_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (bus.char_valid !== 1'b1) begin
         errors++;
         $display("FAIL char_wait: char_valid=%b after %0d cycles, required 1", bus.char_valid, n);
      end
      repeat (5) begin
         tick();
         checks++;
         if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h48 || bus.htif_pcr_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL char_hold: char_valid=%b data=%h req_valid=%b, required 1 48 0",
                     bus.char_valid, bus.char_data, bus.htif_pcr_req_valid);
         end
      end
      crdy_en = 1'b1;
      run_until_done(200, "char");
      checks++;
      if (req_log.size() != 3) begin
         errors++;
         $display("FAIL char_req_count: %0d requests, required 3", req_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log[i] !== exp_log[i]) begin
               errors++;
               $display("FAIL char_req_order: request %0d rw=%b, required %b", i, req_log[i], exp_log[i]);
            end
         end
      end
      checks++;
      if (char_exp.size() != 0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL char_end: %0d bytes unconsumed pass=%b, required 0 and 1", char_exp.size(), pass);
      end
   endtask

   task automatic test_fail_exit();
      do_reset();
      rsp_q = '{64'd0, 64'd7};
      run_until_done(200, "fail7");
      checks++;
      if (pass !== 1'b0 || exit_code !== 63'd3 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL fail7_status: pass=%b exit=%h timeout=%b, required 0 3 0", pass, exit_code, timeout);
      end
      do_reset();
      rsp_q = '{64'h0200_0000_0000_0010};
      run_until_done(200, "fail_cmd");
      checks++;
      if (pass !== 1'b0 || exit_code !== 63'h0100_0000_0000_0008 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL fail_cmd_status: pass=%b exit=%h timeout=%b, required 0 0100000000000008 0",
                  pass, exit_code, timeout);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      max_cycles = 64'd50;
      run_until_done(200, "timeout");
      checks++;
      if (timeout !== 1'b1 || pass !== 1'b0 || cycle_count !== 64'd50) begin
         errors++;
         $display("FAIL timeout_status: timeout=%b pass=%b count=%0d, required 1 0 50", timeout, pass, cycle_count);
      end
      repeat (10) tick();
      checks++;
      if (cycle_count !== 64'd50 || bus.htif_pcr_req_valid !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL timeout_frozen: count=%0d req_valid=%b done=%b, required 50 0 1",
                  cycle_count, bus.htif_pcr_req_valid, done);
      end
   endtask

   task automatic test_boundary();
      do_reset();
      arm_boundary = 1'b1;
      rsp_q = '{64'd0, 64'd1};
      run_until_done(200, "boundary");
      checks++;
      if (timeout !== 1'b0 || pass !== 1'b1 || exit_code !== 63'd0) begin
         errors++;
         $display("FAIL boundary_status: timeout=%b pass=%b exit=%h, required 0 1 0", timeout, pass, exit_code);
      end
      checks++;
      if (cycle_count !== boundary_val || boundary_val == 64'd0) begin
         errors++;
         $display("FAIL boundary_count: count=%0d, required %0d (nonzero)", cycle_count, boundary_val);
      end
   endtask

   task automatic test_reset_clr();
      int n = 0;
      do_reset();
      rsp_q = '{64'h0100_0000_0000_0042};
      while (want_write !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      rdy_en = 1'b0;
      n = 0;
      while (!(bus.htif_pcr_req_valid === 1'b1 && bus.htif_pcr_req_rw === 1'b1) && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (bus.htif_pcr_req_valid !== 1'b1 || bus.htif_pcr_req_rw !== 1'b1) begin
         errors++;
         $display("FAIL clr_wait: req_valid=%b rw=%b, required 1 1", bus.htif_pcr_req_valid, bus.htif_pcr_req_rw);
      end
      @(negedge clk);
      reset = 1'b1;
      bus.htif_pcr_resp_valid = 1'b1;
      bus.htif_pcr_resp_data  = 64'd1;
      @(negedge clk);
      checks++;
      if ({bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_req_addr, bus.htif_pcr_req_data,
           bus.htif_pcr_resp_ready, bus.char_valid, bus.char_data, done, pass, timeout, exit_code,
           cycle_count} !== '0) begin
         errors++;
         $display("FAIL clr_reset_outputs: req_valid=%b rw=%b addr=%h resp_ready=%b char_valid=%b done=%b count=%0d, required all 0",
                  bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_req_addr,
                  bus.htif_pcr_resp_ready, bus.char_valid, done, cycle_count);
      end
      model_clear();
      rdy_en   = 1'b0;
      stray_en = 1'b1;
      reset    = 1'b0;
      cyc      = 0;
      repeat (4) tick();
      checks++;
      if (done !== 1'b0 || bus.htif_pcr_req_valid !== 1'b1 || bus.htif_pcr_req_rw !== 1'b0) begin
         errors++;
         $display("FAIL stray_resp: done=%b req_valid=%b rw=%b, required 0 1 0",
                  done, bus.htif_pcr_req_valid, bus.htif_pcr_req_rw);
      end
      stray_en = 1'b0;
      rdy_en   = 1'b1;
      rsp_q    = '{64'd1};
      run_until_done(200, "after_reset");
      checks++;
      if (pass !== 1'b1 || timeout !== 1'b0 || exit_code !== 63'd0) begin
         errors++;
         $display("FAIL after_reset_status: pass=%b timeout=%b exit=%h, required 1 0 0", pass, timeout, exit_code);
      end
   endtask

   initial begin
      bus.htif_pcr_req_ready  = 1'b0;
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data  = '0;
      bus.char_ready          = 1'b0;
      model_clear();
      cyc = 0;
      test_reset();
      test_exit_pass();
      test_char();
      test_fail_exit();
      test_timeout();
      test_boundary();
      test_reset_clr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
